// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial BCD adder sequencer: one BCD digit per clock, LSD first,
// operands latched on START, one-cycle DONE pulse when the sum is final.
module bcd_serial_add_ctrl #(
    parameter int DIGITS = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic [4*DIGITS-1:0]   A,
    input  logic [4*DIGITS-1:0]   B,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [4*DIGITS-1:0]   SUM,
    output logic                  COUT,
    output logic                  ERR
);

    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    typedef enum logic [1:0] {IDLE, ADD, FIN} state_t;

    state_t             state;
    logic [IDX_W-1:0]   idx_p0;
    logic               carry_p0;
    logic [W-1:0]       a_p0;
    logic [W-1:0]       b_p0;

    logic [3:0]         x;
    logic [3:0]         y;
    logic [4:0]         res;
    logic               dig_err;

    // Returns {carry, digit}; non-BCD inputs still follow the +6 correction rule.
    function automatic logic [4:0] bcd_digit_add(input logic [3:0] dx,
                                                 input logic [3:0] dy,
                                                 input logic       cin);
        logic [4:0] raw;
        logic [4:0] adj;
        raw = {1'b0, dx} + {1'b0, dy} + {4'b0000, cin};
        adj = raw + 5'd6;
        if (raw > 5'd9)
            return {1'b1, adj[3:0]};
        else
            return {1'b0, raw[3:0]};
    endfunction

    function automatic logic digit_invalid(input logic [3:0] d);
        return d > 4'd9;
    endfunction

    always_comb begin
        x       = a_p0[4*int'(idx_p0) +: 4];
        y       = b_p0[4*int'(idx_p0) +: 4];
        res     = bcd_digit_add(x, y, carry_p0);
        dig_err = digit_invalid(x) | digit_invalid(y);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            SUM      <= '0;
            COUT     <= 1'b0;
            ERR      <= 1'b0;
            idx_p0   <= '0;
            carry_p0 <= 1'b0;
        end else begin
            case (state)
                IDLE, FIN: begin
                    DONE <= 1'b0;
                    if (START) begin
                        a_p0     <= A;
                        b_p0     <= B;
                        SUM      <= '0;
                        COUT     <= 1'b0;
                        ERR      <= 1'b0;
                        carry_p0 <= 1'b0;
                        idx_p0   <= '0;
                        BUSY     <= 1'b1;
                        state    <= ADD;
                    end else begin
                        state <= IDLE;
                    end
                end
                ADD: begin
                    // Digit stage: result digit and carry for position idx_p0
                    SUM[4*int'(idx_p0) +: 4] <= res[3:0];
                    carry_p0 <= res[4];
                    ERR      <= ERR | dig_err;
                    if (idx_p0 == LAST_IDX) begin
                        COUT  <= res[4];
                        DONE  <= 1'b1;
                        BUSY  <= 1'b0;
                        state <= FIN;
                    end else begin
                        idx_p0 <= idx_p0 + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Directed bench for bcd_serial_add_ctrl with DIGITS=4 and hand-computed sums.
module tb_bcd_serial_add_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        START;
    logic [15:0] A;
    logic [15:0] B;
    logic        BUSY;
    logic        DONE;
    logic [15:0] SUM;
    logic        COUT;
    logic        ERR;

    int vectors = 0;
    int miscompares = 0;

    bcd_serial_add_ctrl #(.DIGITS(4)) dut (
        .CLK(CLK), .RST(RST), .START(START), .A(A), .B(B),
        .BUSY(BUSY), .DONE(DONE), .SUM(SUM), .COUT(COUT), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] es, input logic ec, input logic ee,
                          input string nm);
        int lat;
        int busy_cnt;
        lat = 0;
        busy_cnt = 0;
        A = a; B = b; START = 1'b1;
        tick();
        START = 1'b0;
        if (BUSY === 1'b1) busy_cnt++;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (DONE === 1'b1) begin
                lat = c;
                break;
            end
            if (BUSY === 1'b1) busy_cnt++;
        end
        vectors++;
        if (lat !== 4) begin
            miscompares++;
            $display("FAIL %s latency: got %0d cycles, want 4", nm, lat);
        end
        vectors++;
        if (busy_cnt !== 4) begin
            miscompares++;
            $display("FAIL %s busy_cycles: got %0d, want 4", nm, busy_cnt);
        end
        vectors++;
        if (SUM !== es || COUT !== ec || ERR !== ee || BUSY !== 1'b0) begin
            miscompares++;
            $display("FAIL %s result: got SUM=%h COUT=%b ERR=%b BUSY=%b, want SUM=%h COUT=%b ERR=%b BUSY=0",
                     nm, SUM, COUT, ERR, BUSY, es, ec, ee);
        end
        tick();
        vectors++;
        if (DONE !== 1'b0 || SUM !== es || COUT !== ec || ERR !== ee) begin
            miscompares++;
            $display("FAIL %s hold: got DONE=%b SUM=%h COUT=%b ERR=%b, want DONE=0 SUM=%h COUT=%b ERR=%b",
                     nm, DONE, SUM, COUT, ERR, es, ec, ee);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1; START = 1'b0; A = 16'h0000; B = 16'h0000;
        tick();
        tick();
        vectors++;
        if (BUSY !== 1'b0 || DONE !== 1'b0 || SUM !== 16'h0000 || COUT !== 1'b0 || ERR !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: got BUSY=%b DONE=%b SUM=%h COUT=%b ERR=%b, want all zero",
                     BUSY, DONE, SUM, COUT, ERR);
        end
        RST = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        run_op(16'h0003, 16'h0005, 16'h0008, 1'b0, 1'b0, "basic_3p5");
    endtask

    task automatic test_carry_chain();
        run_op(16'h9999, 16'h0001, 16'h0000, 1'b1, 1'b0, "carry_9999p1");
        run_op(16'h0004, 16'h0006, 16'h0010, 1'b0, 1'b0, "carry_4p6");
        run_op(16'h4567, 16'h5678, 16'h0245, 1'b1, 1'b0, "carry_4567p5678");
        run_op(16'h0999, 16'h0999, 16'h1998, 1'b0, 1'b0, "carry_999p999");
    endtask

    task automatic test_err();
        run_op(16'h000A, 16'h0000, 16'h0010, 1'b0, 1'b1, "err_nonbcd");
        run_op(16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, "err_cleared");
    endtask

    task automatic test_start_ignored();
        int dones;
        dones = 0;
        A = 16'h1234; B = 16'h1111; START = 1'b1;
        tick();
        A = 16'h9999; B = 16'h9999;
        tick();
        START = 1'b0;
        if (DONE === 1'b1) dones++;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (DONE === 1'b1) begin
                dones++;
                vectors++;
                if (SUM !== 16'h2345 || COUT !== 1'b0 || ERR !== 1'b0) begin
                    miscompares++;
                    $display("FAIL ignore_start_result: got SUM=%h COUT=%b ERR=%b, want SUM=2345 COUT=0 ERR=0",
                             SUM, COUT, ERR);
                end
            end
        end
        vectors++;
        if (dones !== 1) begin
            miscompares++;
            $display("FAIL ignore_start_done_count: got %0d, want 1", dones);
        end
    endtask

    task automatic test_back_to_back();
        int first;
        int second;
        first = 0;
        second = 0;
        A = 16'h0001; B = 16'h0001; START = 1'b1;
        tick();
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (DONE === 1'b1) begin
                if (first == 0) begin
                    first = c;
                    vectors++;
                    if (SUM !== 16'h0002) begin
                        miscompares++;
                        $display("FAIL b2b_sum1: got %h, want 0002", SUM);
                    end
                    A = 16'h0002; B = 16'h0002;
                end else begin
                    second = c;
                    vectors++;
                    if (SUM !== 16'h0004) begin
                        miscompares++;
                        $display("FAIL b2b_sum2: got %h, want 0004", SUM);
                    end
                    START = 1'b0;
                    break;
                end
            end
        end
        START = 1'b0;
        vectors++;
        if (first !== 4 || second !== 9) begin
            miscompares++;
            $display("FAIL b2b_timing: got DONE at %0d,%0d, want 4,9", first, second);
        end
        tick();
        tick();
        vectors++;
        if (BUSY !== 1'b0 || DONE !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_idle: got BUSY=%b DONE=%b, want 0 0", BUSY, DONE);
        end
    endtask

    task automatic test_reset_mid_op();
        int dones;
        dones = 0;
        A = 16'h5555; B = 16'h4444; START = 1'b1;
        tick();
        START = 1'b0;
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        vectors++;
        if (BUSY !== 1'b0 || DONE !== 1'b0 || SUM !== 16'h0000 || COUT !== 1'b0 || ERR !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_state: got BUSY=%b DONE=%b SUM=%h COUT=%b ERR=%b, want all zero",
                     BUSY, DONE, SUM, COUT, ERR);
        end
        for (int c = 0; c < 8; c++) begin
            tick();
            if (DONE === 1'b1 || BUSY === 1'b1) dones++;
        end
        vectors++;
        if (dones !== 0) begin
            miscompares++;
            $display("FAIL midreset_quiet: got %0d active cycles, want 0", dones);
        end
        run_op(16'h2718, 16'h3141, 16'h5859, 1'b0, 1'b0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry_chain();
        test_err();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bcd_serial_add_ctrl.md
Name: bcd_serial_add_ctrl

Overview:
Sequencer for a multi-digit BCD add built around a single one-digit BCD adder stage. It adds one digit per clock, least-significant digit first, and carries between digits in a register. It latches operands on a START handshake and signals completion with a one-cycle DONE pulse. It sits between the adder datapath and any requester that needs DIGITS-wide packed BCD sums.

Parameters:
DIGITS, 4, number of BCD digits per operand. Minimum 1. Operand width is 4*DIGITS.

Ports:
CLK  input  1  system clock; all state changes on the rising edge
RST  input  1  reset, synchronous, active-high
START  input  1  request; sampled only in IDLE or FIN
A  input  4*DIGITS  packed BCD operand; digit i is A[4i+3:4i]; sampled when START is accepted
B  input  4*DIGITS  packed BCD operand, same layout as A
BUSY  output  1  operation in progress (state ADD)
DONE  output  1  one-cycle pulse; SUM, COUT and ERR are final
SUM  output  4*DIGITS  packed BCD result
COUT  output  1  carry out of the most-significant digit
ERR  output  1  some operand digit was greater than 9 in this operation

Behaviour:
- Reset (RST=1 at an edge, dominant over everything): state=IDLE, BUSY=0, DONE=0, SUM=0, COUT=0, ERR=0, digit index=0, carry register=0. A reset mid-operation aborts the operation with no DONE.
- All outputs are registered.
- FSM states: IDLE, ADD, FIN.
- IDLE with START=1:
  - latch A and B into internal registers
  - clear SUM, COUT, ERR and the carry register
  - set digit index=0, go to ADD, set BUSY=1
- IDLE with START=0: hold; SUM, COUT and ERR keep their last values.
- ADD, each edge, for digit index i:
  - x=A_reg digit i, y=B_reg digit i, cin=carry register
  - raw=x+y+cin, computed 5 bits wide
  - if raw>9: s=(raw+6)[3:0], c=1; else s=raw[3:0], c=0
  - write s into SUM digit i; carry register<=c
  - ERR<=ERR | (x>9) | (y>9)
  - if i==DIGITS-1: COUT<=c, DONE<=1, BUSY<=0, state<=FIN; else i<=i+1
- Arithmetic is defined for all 16 digit codes. Non-BCD digits give the formula result and set ERR.
- START while in ADD is ignored. No queueing; the requester must re-assert START.
- FIN lasts exactly one cycle with DONE=1. At the next edge DONE<=0, and:
  - START=1: accept as in IDLE (back-to-back operation)
  - START=0: go to IDLE
- Latency: START accepted at edge k. BUSY=1 after edges k..k+DIGITS-1. DONE=1 after edge k+DIGITS, for exactly one cycle.
  - Back-to-back issue interval is DIGITS+1 cycles.
  - DIGITS=1 gives one ADD cycle.
- SUM is progressively updated during ADD. It is valid only from the DONE cycle onward and holds until the next accepted START.
- Changes on A or B after acceptance have no effect on the operation in progress.
- Digit index register width is max(1, clog2(DIGITS)).

Test Plan:
DIGITS=4, all values hex-packed BCD.
1. A=0003, B=0005, one-cycle START → DONE pulses exactly 4 cycles after the accept edge; SUM=0008, COUT=0, ERR=0; BUSY high for 4 cycles.
2. Carry chain:
   - 9999+0001 → SUM=0000, COUT=1
   - 0004+0006 → SUM=0010, COUT=0
   - 4567+5678 → SUM=0245, COUT=1
   - 0999+0999 → SUM=1998, COUT=0
3. A=000A, B=0000 → ERR=1 at DONE, SUM=0010. The next operation 0001+0001 → ERR=0, SUM=0002.
4. START pulsed during ADD with different A and B → ignored; result matches the first operands; exactly one DONE.
5. START held high continuously with 0001+0001 then 0002+0002 → DONE every 5 cycles; sums 0002 then 0004.
6. RST=1 for one cycle at the 2nd ADD cycle → next cycle all outputs 0, IDLE, no DONE. A new START then completes normally.
